// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared CPU bus register map and OAM DMA state encoding
package nes_bus_pkg;

   localparam logic [15:0] PPU_CTRL_ADDR   = 16'h2000;
   localparam logic [15:0] PPU_MASK_ADDR   = 16'h2001;
   localparam logic [15:0] PPU_STATUS_ADDR = 16'h2002;
   localparam logic [15:0] OAM_ADDR_ADDR   = 16'h2003;
   localparam logic [15:0] OAM_DATA_ADDR   = 16'h2004;
   localparam logic [15:0] PPU_SCROLL_ADDR = 16'h2005;
   localparam logic [15:0] PPU_ADDR_ADDR   = 16'h2006;
   localparam logic [15:0] PPU_DATA_ADDR   = 16'h2007;
   localparam logic [15:0] DMA_REG_ADDR    = 16'h4014;
   localparam logic [15:0] APU_STATUS_ADDR = 16'h4015;
   localparam logic [15:0] JOY1_ADDR       = 16'h4016;

   localparam int DMA_XFER_LEN = 256;

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - CPU bus / DMA signal bundle between the CPU side and the DMA engine
interface oam_dma_if;
   import nes_bus_pkg::*;

   logic [15:0] cpu_addr;
   logic        cpu_write;
   logic [7:0]  cpu_dout;
   logic [7:0]  bus_din;
   logic        cpu_rdy;
   logic        dma_active;
   logic [15:0] dma_addr;
   logic        dma_write;
   logic [7:0]  dma_dout;
   logic [15:0] bus_addr;
   logic        bus_write;
   logic [7:0]  bus_dout;

   modport slave (
      input  cpu_addr, cpu_write, cpu_dout, bus_din,
      output cpu_rdy, dma_active, dma_addr, dma_write, dma_dout,
      output bus_addr, bus_write, bus_dout
   );

   modport master (
      output cpu_addr, cpu_write, cpu_dout, bus_din,
      input  cpu_rdy, dma_active, dma_addr, dma_write, dma_dout,
      input  bus_addr, bus_write, bus_dout
   );

endinterface

// File: rtl/cpu_bus_mux.sv
// rtl/cpu_bus_mux.sv - selects the shared bus owner between the CPU core and OAM DMA
module cpu_bus_mux
   import nes_bus_pkg::*;
(
   input  logic        dma_active,
   input  logic [15:0] dma_addr,
   input  logic        dma_write,
   input  logic [7:0]  dma_dout,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_dout,
   output logic [15:0] bus_addr,
   output logic        bus_write,
   output logic [7:0]  bus_dout
);

   // DMA owns the address/data/strobe lines whenever it is active, CPU otherwise
   always_comb begin
      bus_addr  = cpu_addr;
      bus_write = cpu_write;
      bus_dout  = cpu_dout;
      if (dma_active) begin
         bus_addr  = dma_addr;
         bus_write = dma_write;
         bus_dout  = dma_dout;
      end
   end

endmodule

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - $4014 OAM DMA engine: halts the CPU and copies one page to $2004
module oam_dma #(
   parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR,
   parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR,
   parameter int          XFER_LEN      = nes_bus_pkg::DMA_XFER_LEN
) (
   input logic        Clk,
   input logic        reset,
   oam_dma_if.slave   bus
);
   import nes_bus_pkg::*;

   localparam logic [2:0] S_IDLE  = 3'(IDLE);
   localparam logic [2:0] S_HALT  = 3'(HALT);
   localparam logic [2:0] S_ALIGN = 3'(ALIGN);
   localparam logic [2:0] S_READ  = 3'(READ);
   localparam logic [2:0] S_WRITE = 3'(WRITE);

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   logic [2:0]  state, state_nx;
   logic [7:0]  page, page_nx;
   logic [7:0]  idx, idx_nx;
   logic [7:0]  data_reg, data_nx;
   logic        cyc_odd;
   logic        trigger;

   logic        cpu_rdy_q, dma_active_q, dma_write_q;
   logic [15:0] dma_addr_q;
   logic [7:0]  dma_dout_q;

   assign trigger = bus.cpu_write && (bus.cpu_addr == DMA_REG_ADDR);

   // next-state and counter logic; READ samples the memory map, WRITE advances idx
   always_comb begin
      state_nx = state;
      page_nx  = page;
      idx_nx   = idx;
      data_nx  = data_reg;
      case (state)
         S_IDLE: begin
            if (trigger) begin
               state_nx = S_HALT;
               page_nx  = bus.cpu_dout;
               idx_nx   = 8'h00;
            end
         end
         S_HALT:  state_nx = cyc_odd ? S_READ : S_ALIGN;
         S_ALIGN: state_nx = S_READ;
         S_READ: begin
            data_nx  = bus.bus_din;
            state_nx = S_WRITE;
         end
         S_WRITE: begin
            if (idx == LAST_IDX) begin
               state_nx = S_IDLE;
            end else begin
               idx_nx   = idx + 8'd1;
               state_nx = S_READ;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // state, counters and outputs all registered; outputs decoded from the upcoming state
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         page         <= 8'h00;
         idx          <= 8'h00;
         data_reg     <= 8'h00;
         cyc_odd      <= 1'b0;
         cpu_rdy_q    <= 1'b1;
         dma_active_q <= 1'b0;
         dma_write_q  <= 1'b0;
         dma_addr_q   <= 16'h0000;
         dma_dout_q   <= 8'h00;
      end else begin
         state        <= state_nx;
         page         <= page_nx;
         idx          <= idx_nx;
         data_reg     <= data_nx;
         cyc_odd      <= ~cyc_odd;
         cpu_rdy_q    <= (state_nx == S_IDLE);
         dma_active_q <= (state_nx == S_READ) || (state_nx == S_WRITE);
         dma_write_q  <= (state_nx == S_WRITE);
         dma_addr_q   <= (state_nx == S_READ)  ? {page_nx, idx_nx} :
                         (state_nx == S_WRITE) ? OAM_DATA_ADDR : 16'h0000;
         dma_dout_q   <= (state_nx == S_WRITE) ? data_nx : 8'h00;
      end
   end

   assign bus.cpu_rdy    = cpu_rdy_q;
   assign bus.dma_active = dma_active_q;
   assign bus.dma_write  = dma_write_q;
   assign bus.dma_addr   = dma_addr_q;
   assign bus.dma_dout   = dma_dout_q;

   cpu_bus_mux u_bus_mux (
      .dma_active (dma_active_q),
      .dma_addr   (dma_addr_q),
      .dma_write  (dma_write_q),
      .dma_dout   (dma_dout_q),
      .cpu_addr   (bus.cpu_addr),
      .cpu_write  (bus.cpu_write),
      .cpu_dout   (bus.cpu_dout),
      .bus_addr   (bus.bus_addr),
      .bus_write  (bus.bus_write),
      .bus_dout   (bus.bus_dout)
   );

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - scoreboard bench for the OAM DMA engine
module tb_oam_dma;
   import nes_bus_pkg::*;

   logic Clk   = 1'b0;
   logic reset = 1'b1;
   always #5 Clk = ~Clk;

   oam_dma_if bus();

   oam_dma dut (
      .Clk   (Clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] mem [0:65535];
   assign bus.bus_din = mem[bus.bus_addr];

   int total   = 0;
   int bad     = 0;
   int cnt     = 0;
   int run     = 0;
   int wr_seen = 0;

   logic [15:0] rq [$];
   logic [7:0]  wq [$];
   int          sq [$];

   // reference get/put parity: clocks since reset release
   always @(posedge Clk or negedge reset) begin
      if (!reset) cnt <= 0;
      else        cnt <= cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // monitor: pops expected reads, writes and stall lengths as the DUT presents them
   always @(negedge Clk) begin
      if (!reset) begin
         run = 0;
      end else begin
         if (bus.dma_active && bus.dma_write) begin
            wr_seen++;
            chk("wr_addr", bus.dma_addr, OAM_DATA_ADDR);
            if (wq.size() == 0) chk("wr_pending", wq.size(), 1);
            else                chk("wr_data", bus.dma_dout, wq.pop_front());
         end else if (bus.dma_active) begin
            chk("rd_parity", cnt & 1, 0);
            if (rq.size() == 0) chk("rd_pending", rq.size(), 1);
            else                chk("rd_addr", bus.dma_addr, rq.pop_front());
         end
         if (!bus.cpu_rdy) begin
            run++;
         end else if (run > 0) begin
            if (sq.size() == 0) chk("stall_pending", sq.size(), 1);
            else                chk("stall_len", run, sq.pop_front());
            run = 0;
         end
      end
   end

   task automatic chk_reset(input string name);
      chk({name, "_rdy"},  bus.cpu_rdy,    1'b1);
      chk({name, "_act"},  bus.dma_active, 1'b0);
      chk({name, "_addr"}, bus.dma_addr,   16'h0000);
      chk({name, "_wr"},   bus.dma_write,  1'b0);
      chk({name, "_dout"}, bus.dma_dout,   8'h00);
   endtask

   // want: required HALT parity (1 = no ALIGN, 0 = ALIGN), -1 = take whatever comes
   task automatic trig(input logic [7:0] pg, input int want);
      @(negedge Clk);
      if (want >= 0 && ((cnt + 1) & 1) != want) @(negedge Clk);
      sq.push_back((((cnt + 1) & 1) == 1) ? 513 : 514);
      for (int i = 0; i < 256; i++) begin
         rq.push_back({pg, 8'(i)});
         if (pg == 8'h03) wq.push_back(8'(i) ^ 8'hA5);
         else             wq.push_back(mem[{pg, 8'(i)}]);
      end
      bus.cpu_addr  = DMA_REG_ADDR;
      bus.cpu_write = 1'b1;
      bus.cpu_dout  = pg;
      @(negedge Clk);
      bus.cpu_addr  = 16'h0000;
      bus.cpu_write = 1'b0;
      bus.cpu_dout  = 8'h00;
   endtask

   task automatic wait_idle(input string name);
      int g = 0;
      while ((rq.size() + wq.size() + sq.size()) != 0 && g < 3000) begin
         @(negedge Clk);
         #1;
         g++;
      end
      chk({name, "_done"}, rq.size() + wq.size() + sq.size(), 0);
   endtask

   initial begin
      int base;
      int g;
      for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h3C;
      for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
      bus.cpu_addr  = 16'h0000;
      bus.cpu_write = 1'b0;
      bus.cpu_dout  = 8'h00;

      #1 reset = 1'b0;
      #2 chk_reset("rst");
      repeat (3) @(negedge Clk);
      reset = 1'b1;
      #1 chk_reset("rst_rel");

      trig(8'h02, 1);
      repeat (20) @(negedge Clk);
      bus.cpu_addr  = DMA_REG_ADDR;
      bus.cpu_write = 1'b1;
      bus.cpu_dout  = 8'h09;
      @(negedge Clk);
      bus.cpu_write = 1'b0;
      bus.cpu_addr  = 16'h0000;
      bus.cpu_dout  = 8'h00;
      wait_idle("odd");

      trig(8'h02, 0);
      wait_idle("align");

      trig(8'h03, -1);
      wait_idle("pat");

      @(negedge Clk);
      bus.cpu_addr  = DMA_REG_ADDR;
      bus.cpu_write = 1'b0;
      bus.cpu_dout  = 8'h07;
      @(negedge Clk);
      bus.cpu_addr  = APU_STATUS_ADDR;
      bus.cpu_write = 1'b1;
      @(negedge Clk);
      bus.cpu_addr  = 16'h0000;
      bus.cpu_write = 1'b0;
      bus.cpu_dout  = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         #1;
         chk("notrig_rdy", bus.cpu_rdy, 1'b1);
         chk("notrig_act", bus.dma_active, 1'b0);
      end

      trig(8'h04, -1);
      base = wr_seen;
      g = 0;
      while (wr_seen < base + 100 && g < 1000) begin
         @(negedge Clk);
         #1;
         g++;
      end
      chk("abort_reach", wr_seen - base, 100);
      reset = 1'b0;
      #1 chk_reset("abort");
      rq.delete();
      wq.delete();
      sq.delete();
      @(negedge Clk);
      #1 chk_reset("abort_hold");
      reset = 1'b1;
      @(negedge Clk);
      #1 chk_reset("abort_rel");

      trig(8'h05, -1);
      wait_idle("after_abort");

      repeat (2) @(negedge Clk);
      trig(8'h06, -1);
      wait_idle("retrig");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- OAM DMA engine on the CPU bus, directly downstream of the 2A03 CPU core.
- It decodes CPU writes to the DMA register ($4014) and halts the CPU via `cpu_rdy`.
- It then takes over the address bus and copies 256 bytes from page $XX00-$XXFF to the PPU OAM data port ($2004).
- The top level muxes `dma_addr`/`dma_write`/`dma_dout` onto the shared bus while `dma_active` is high.

Parameters:
- `DMA_REG_ADDR`, 16'h4014, CPU write address that triggers a transfer.
- `OAM_DATA_ADDR`, 16'h2004, destination address for every DMA write.
- `XFER_LEN`, 256, bytes per transfer; must be a power of two, max 256.

Ports:
- `Clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cpu_addr` input 16: CPU address bus output.
- `cpu_write` input 1: CPU write strobe.
- `cpu_dout` input 8: CPU write data (page number on trigger).
- `bus_din` input 8: data returned by the memory map for the current bus address, valid in the same cycle.
- `cpu_rdy` output 1: 1 = CPU may advance; 0 = CPU holds its state.
- `dma_active` output 1: 1 = DMA owns the bus.
- `dma_addr` output 16: DMA bus address.
- `dma_write` output 1: DMA write strobe.
- `dma_dout` output 8: DMA write data.

Behaviour:
- Reset (`reset`=0, async): state=IDLE, `cpu_rdy`=1, `dma_active`=0, `dma_addr`=16'h0000, `dma_write`=0, `dma_dout`=8'h00, page=0, idx=0, `cyc_odd`=0.
- `cyc_odd` toggles every clock from reset. It is the CPU "get/put" parity.
- All outputs are registered, decoded from state and counters; no combinational path from the inputs.
- IDLE:
  - Trigger = `cpu_write` && `cpu_addr`==`DMA_REG_ADDR`.
  - On trigger, latch page<=`cpu_dout`, idx<=0, go to HALT.
  - Otherwise stay in IDLE.
- HALT (1 cycle):
  - `cpu_rdy`=0, `dma_active`=0; the CPU's triggering write has already completed.
  - If `cyc_odd`==1, go to READ; else go to ALIGN.
- ALIGN (1 cycle): `cpu_rdy`=0, `dma_active`=0, then go to READ. This guarantees every READ cycle has `cyc_odd`==0.
- READ:
  - `cpu_rdy`=0, `dma_active`=1, `dma_addr`={page, idx}, `dma_write`=0.
  - At the clock edge ending the cycle, data_reg<=`bus_din`; go to WRITE.
- WRITE:
  - `cpu_rdy`=0, `dma_active`=1, `dma_addr`=`OAM_DATA_ADDR`, `dma_write`=1, `dma_dout`=data_reg.
  - If idx==`XFER_LEN`-1, go to IDLE; else idx<=idx+1 and go to READ.
- idx is 8 bits and wraps only via the terminal check. The page byte is never incremented.
- Total CPU stall from the cycle after the trigger write: 513 cycles (no ALIGN) or 514 cycles (ALIGN inserted).
- `cpu_rdy` returns to 1 in the first IDLE cycle after the final WRITE. That cycle ignores triggers only if `cpu_rdy` was 0 in it; otherwise a new trigger is accepted normally.
- Writes to `DMA_REG_ADDR` seen while not in IDLE are ignored. The CPU is halted then, so this arises only from bench stimulus.
- CPU reads of `DMA_REG_ADDR` (`cpu_write`=0) never trigger.
- Reset asserted mid-transfer aborts immediately: outputs go to their reset values, the CPU is released, and the partial OAM contents are left as-is.
- Page $40 or $20 sources are legal; reads go to whatever the memory map returns.

Decomposition:
- Shared package `nes_bus_pkg`:
  - Constants `DMA_REG_ADDR` and `OAM_DATA_ADDR`, plus the other PPU/APU register addresses.
  - `typedef enum logic [2:0] dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}`.
- Natural sub-module: `cpu_bus_mux`, a small top-level bus owner selector.
  - Selects {`dma_addr`, `dma_write`, `dma_dout`} when `dma_active`, else the CPU signals.
  - Owns nothing sequential; oam_dma itself stays a single FSM module.

Test Plan:
- Reset, then a CPU write of 8'h02 to 16'h4014 with `cyc_odd`=1 in HALT:
  - Expect HALT→READ with no ALIGN.
  - First READ `dma_addr`=16'h0200; last WRITE at idx 255.
  - `cpu_rdy` low for exactly 513 cycles.
- Same stimulus with `cyc_odd`=0 in HALT: ALIGN inserted, `cpu_rdy` low for exactly 514 cycles, all READ cycles have `cyc_odd`=0.
- Memory model with RAM[$0300+i]=i^8'hA5, trigger page 8'h03:
  - Expect 256 writes to 16'h2004 with data 8'hA5, 8'hA4, ... 8'h5A, in order.
  - `dma_write` never asserts on a read address.
- CPU read of $4014, and a write to $4015, with data 8'h07: `cpu_rdy` stays 1 and `dma_active` stays 0.
- Drop `reset` low after the 100th WRITE:
  - Outputs reach reset values immediately (async).
  - After release, `cpu_rdy`=1 and a new trigger with page 8'h05 starts cleanly at 16'h0500.
- Second trigger issued 3 cycles after `cpu_rdy` returns: accepted, full 256-byte transfer repeated with the new page.
